// File: rtl/multiplier_seq_shift_add.sv
// Sequential shift-add multiplier: BPC multiplier bits per cycle, valid/ready on both
// sides, signed operands handled as sign-magnitude with a final conditional negate.
module multiplier_seq_shift_add #(
    parameter int DW  = 8,
    parameter int BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    input  logic              sgn,
    input  logic              abort,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [2*DW-1:0]   result,
    output logic              busy
);

    localparam int RW = 2 * DW;
    localparam int N  = DW / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [DW-1:0]   a_r;
    logic [DW-1:0]   b_r;
    logic            neg_r;
    logic [CW-1:0]   count_r;
    logic [RW-1:0]   acc_r;
    logic [RW-1:0]   result_r;

    logic [DW-1:0]   a_mag_s;
    logic [DW-1:0]   b_mag_s;
    logic            neg_s;
    logic [RW-1:0]   partial_s;
    logic [RW-1:0]   term_s;
    logic [RW-1:0]   acc_next_s;
    logic            last_s;

    // Operand magnitudes; -2^(DW-1) maps onto itself, which is its correct unsigned magnitude
    always_comb begin
        if (sgn && a[DW-1]) begin
            a_mag_s = {DW{1'b0}} - a;
        end else begin
            a_mag_s = a;
        end
        if (sgn && b[DW-1]) begin
            b_mag_s = {DW{1'b0}} - b;
        end else begin
            b_mag_s = b;
        end
        neg_s = sgn & (a[DW-1] ^ b[DW-1]);
    end

    // One partial product per cycle, weighted by the bit position already consumed
    always_comb begin
        partial_s  = RW'(b_r[BPC-1:0]) * RW'(a_r);
        term_s     = partial_s << (32'(count_r) * BPC);
        acc_next_s = acc_r + term_s;
        last_s     = (count_r == CW'(N - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort outranks both handshakes
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_vld) begin
                    state_s = S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_DONE: begin
                if (abort || out_rdy) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        busy    = 1'b0;
        case (state_r)
            S_IDLE:  in_rdy = 1'b1;
            S_CALC:  busy   = 1'b1;
            S_DONE: begin
                out_vld = 1'b1;
                busy    = 1'b1;
            end
            default: in_rdy = 1'b0;
        endcase
    end

    // Datapath: load on accept, accumulate in CALC, commit result only on the final step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= {DW{1'b0}};
            b_r      <= {DW{1'b0}};
            neg_r    <= 1'b0;
            count_r  <= {CW{1'b0}};
            acc_r    <= {RW{1'b0}};
            result_r <= {RW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_vld) begin
                        a_r     <= a_mag_s;
                        b_r     <= b_mag_s;
                        neg_r   <= neg_s;
                        count_r <= {CW{1'b0}};
                        acc_r   <= {RW{1'b0}};
                    end
                end
                S_CALC: begin
                    if (!abort) begin
                        acc_r   <= acc_next_s;
                        b_r     <= b_r >> BPC;
                        count_r <= count_r + CW'(1);
                        if (last_s) begin
                            result_r <= neg_r ? ({RW{1'b0}} - acc_next_s) : acc_next_s;
                        end
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign result = result_r;

endmodule

// File: tb/tb_multiplier_seq_shift_add.sv
// Directed bench for the shift-add multiplier; three instances (BPC=1,2,4) share the
// same stimulus so latency and results are checked for each digit width.
module tb_multiplier_seq_shift_add;

    localparam int DW = 8;
    localparam int NI = 3;
    localparam int NV [NI] = '{8, 4, 2};

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic        abort;
    logic        out_rdy;
    logic        in_rdy_v  [NI];
    logic        out_vld_v [NI];
    logic        busy_v    [NI];
    logic [15:0] result_v  [NI];

    int checks;
    int failures;

    multiplier_seq_shift_add #(.DW(DW), .BPC(1)) dut1 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_v[0]), .a(a), .b(b),
        .sgn(sgn), .abort(abort), .out_vld(out_vld_v[0]), .out_rdy(out_rdy),
        .result(result_v[0]), .busy(busy_v[0])
    );
    multiplier_seq_shift_add #(.DW(DW), .BPC(2)) dut2 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_v[1]), .a(a), .b(b),
        .sgn(sgn), .abort(abort), .out_vld(out_vld_v[1]), .out_rdy(out_rdy),
        .result(result_v[1]), .busy(busy_v[1])
    );
    multiplier_seq_shift_add #(.DW(DW), .BPC(4)) dut4 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_v[2]), .a(a), .b(b),
        .sgn(sgn), .abort(abort), .out_vld(out_vld_v[2]), .out_rdy(out_rdy),
        .result(result_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation with out_rdy high; operands and sgn are scrambled after accept
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic os,
                          input logic [15:0] exp_res);
        int          lat [NI];
        int          hi  [NI];
        logic [15:0] got [NI];
        int          edges;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("idle_rdy%0d", i), 32'(in_rdy_v[i]), 32'd1);
            lat[i] = -1;
            hi[i]  = 0;
            got[i] = 16'h0000;
        end
        a = oa; b = ob; sgn = os; in_vld = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        edges = 1;
        in_vld = 1'b0; a = ~oa; b = ~ob; sgn = ~os;
        repeat (12) begin
            for (int i = 0; i < NI; i++) begin
                if (out_vld_v[i]) begin
                    if (hi[i] == 0) begin
                        lat[i] = edges;
                        got[i] = result_v[i];
                    end
                    hi[i]++;
                end
            end
            @(negedge clk);
            edges++;
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("res%0d_%h_%h_%0d", i, oa, ob, os), 32'(got[i]), 32'(exp_res));
            check($sformatf("lat%0d", i), 32'(lat[i]), 32'(NV[i] + 1));
            check($sformatf("pulse%0d", i), 32'(hi[i]), 32'd1);
        end
    endtask

    typedef struct {
        logic        s;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [10] = '{
        '{1'b0, 8'hFF, 8'hFF, 16'hFE01},
        '{1'b1, 8'h80, 8'h80, 16'h4000},
        '{1'b1, 8'hFD, 8'h05, 16'hFFF1},
        '{1'b1, 8'h00, 8'h80, 16'h0000},
        '{1'b0, 8'h0D, 8'h0B, 16'h008F},
        '{1'b1, 8'hFF, 8'hFF, 16'h0001},
        '{1'b1, 8'h7F, 8'h80, 16'hC080},
        '{1'b0, 8'h80, 8'h02, 16'h0100},
        '{1'b1, 8'hFE, 8'h7F, 16'hFF02},
        '{1'b0, 8'h00, 8'hFF, 16'h0000}
    };

    initial begin
        int          np  [NI];
        logic [15:0] r0  [NI];
        logic [15:0] r1  [NI];
        int          cnt;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rs;
        logic [15:0] rp;
        checks = 0; failures = 0;
        rst = 1'b1; in_vld = 1'b0; a = 8'h00; b = 8'h00; sgn = 1'b0; abort = 1'b0; out_rdy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_in_rdy%0d", i), 32'(in_rdy_v[i]), 32'd1);
            check($sformatf("rst_out_vld%0d", i), 32'(out_vld_v[i]), 32'd0);
            check($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_result%0d", i), 32'(result_v[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) run_op(vecs[k].x, vecs[k].y, vecs[k].s, vecs[k].p);

        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rp = rs ? 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}))
                    : 16'({8'h00, ra} * {8'h00, rb});
            run_op(ra, rb, rs, rp);
        end

        // Backpressure: hold DONE for five cycles
        @(negedge clk);
        a = 8'h12; b = 8'h34; sgn = 1'b0; in_vld = 1'b1; out_rdy = 1'b0;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (10) @(negedge clk);
        repeat (5) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("bp_vld%0d", i), 32'(out_vld_v[i]), 32'd1);
                check($sformatf("bp_res%0d", i), 32'(result_v[i]), 32'h03A8);
                check($sformatf("bp_rdy%0d", i), 32'(in_rdy_v[i]), 32'd0);
            end
            @(negedge clk);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("bp_rel_vld%0d", i), 32'(out_vld_v[i]), 32'd0);
            check($sformatf("bp_rel_rdy%0d", i), 32'(in_rdy_v[i]), 32'd1);
        end

        // in_vld held high with changing operands: one accept per IDLE visit
        a = 8'h03; b = 8'h04; sgn = 1'b0; in_vld = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        a = 8'h05; b = 8'h06;
        for (int i = 0; i < NI; i++) begin
            np[i] = 0; r0[i] = 16'h0000; r1[i] = 16'h0000;
        end
        repeat (22) begin
            for (int i = 0; i < NI; i++) begin
                if (out_vld_v[i]) begin
                    if (np[i] == 0) r0[i] = result_v[i];
                    else if (np[i] == 1) r1[i] = result_v[i];
                    np[i]++;
                end
            end
            @(negedge clk);
        end
        in_vld = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("hold_first%0d", i), 32'(r0[i]), 32'h000C);
            check($sformatf("hold_second%0d", i), 32'(r1[i]), 32'h001E);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-CALC at count=3
        a = 8'h77; b = 8'h99; sgn = 1'b0; in_vld = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midrst_rdy%0d", i), 32'(in_rdy_v[i]), 32'd1);
            check($sformatf("midrst_vld%0d", i), 32'(out_vld_v[i]), 32'd0);
            check($sformatf("midrst_busy%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("midrst_res%0d", i), 32'(result_v[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Abort during CALC: no result, result register untouched
        @(negedge clk);
        a = 8'h0F; b = 8'h0F; in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cnt = 0;
        for (int i = 0; i < NI; i++) check($sformatf("abc_rdy%0d", i), 32'(in_rdy_v[i]), 32'd1);
        repeat (12) begin
            for (int i = 0; i < NI; i++) if (out_vld_v[i]) cnt++;
            @(negedge clk);
        end
        check("abc_no_vld", 32'(cnt), 32'd0);
        for (int i = 0; i < NI; i++) check($sformatf("abc_res%0d", i), 32'(result_v[i]), 32'd0);

        // Abort together with out_rdy in DONE: no duplicate result
        a = 8'h11; b = 8'h11; in_vld = 1'b1; out_rdy = 1'b0;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("abd_vld%0d", i), 32'(out_vld_v[i]), 32'd1);
            check($sformatf("abd_res%0d", i), 32'(result_v[i]), 32'h0121);
        end
        abort = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cnt = 0;
        repeat (10) begin
            for (int i = 0; i < NI; i++) if (out_vld_v[i]) cnt++;
            @(negedge clk);
        end
        check("abd_no_vld", 32'(cnt), 32'd0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("abd_rdy%0d", i), 32'(in_rdy_v[i]), 32'd1);
            check($sformatf("abd_keep%0d", i), 32'(result_v[i]), 32'h0121);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
